cycle_meas_ctrl: RTL and testbench

CYCLE_MEAS_CTRL -- requirements
Module: cycle_meas_ctrl

---
 rtl/cycle_meas_ctrl.sv | 130 +++++++++++++
 tb/tb_cycle_meas_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cycle_meas_ctrl.sv
// PicoBlaze-mapped cycle measurement controller: starts/stops an external 8-bit
// counter, captures results into a 4-deep FWFT FIFO and reports sticky status.
module cycle_meas_ctrl #(
  parameter logic [7:0] START_ADDR  = 8'hF0,
  parameter logic [7:0] STOP_ADDR   = 8'hF1,
  parameter logic [7:0] RESULT_ADDR = 8'hF2,
  parameter logic [7:0] STATUS_ADDR = 8'hF3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] cnt_value,
  output logic       cnt_enable,
  output logic       cnt_clear,
  output logic [7:0] in_port_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cnt_enable_q, cnt_enable_d;
  logic        wrap_q, wrap_d;
  logic        drop_q, drop_d;

  logic [7:0]  mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;

  logic        start_wr, stop_wr, result_rd, status_rd;
  logic        fifo_empty, fifo_full;
  logic        push, pop, push_ok;
  logic        wrap_set, drop_set;

  assign start_wr  = write_strobe && (port_id == START_ADDR);
  assign stop_wr   = write_strobe && (port_id == STOP_ADDR);
  assign result_rd = read_strobe  && (port_id == RESULT_ADDR);
  assign status_rd = read_strobe  && (port_id == STATUS_ADDR);

  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'd4);

  // The counter advances on negedge, so cnt_value is already frozen in CAPTURE.
  assign push    = (state_q == CAPTURE);
  assign pop     = result_rd && !fifo_empty;
  assign push_ok = push && (!fifo_full || pop);

  assign wrap_set = (state_q == RUN) && cnt_enable_q && (cnt_value == 8'hFF);
  assign drop_set = push && fifo_full && !pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_wr) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN:     if (stop_wr) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_enable_d = (state_d == RUN);
  end

  // Set events take priority over the clear-on-status-read.
  always_comb begin
    wrap_d = wrap_q;
    drop_d = drop_q;
    if (status_rd) begin
      wrap_d = 1'b0;
      drop_d = 1'b0;
    end
    if (wrap_set) wrap_d = 1'b1;
    if (drop_set) drop_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 2'd1;
    if (pop)     rd_ptr_d = rd_ptr_q + 2'd1;
    if (push_ok && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push_ok) count_d = count_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_enable_q <= 1'b0;
      wrap_q       <= 1'b0;
      drop_q       <= 1'b0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
    end else begin
      state_q      <= state_d;
      cnt_enable_q <= cnt_enable_d;
      wrap_q       <= wrap_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= cnt_value;
  end

  always_comb begin
    in_port_data = 8'h00;
    if (port_id == RESULT_ADDR) begin
      if (!fifo_empty) in_port_data = mem_q[rd_ptr_q];
    end else if (port_id == STATUS_ADDR) begin
      in_port_data = {3'b000, wrap_q, drop_q, busy, fifo_full, fifo_empty};
    end
  end

  assign cnt_enable = cnt_enable_q;
  assign cnt_clear  = reset || (state_q == CLEAR);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cycle_meas_ctrl.sv
// Randomized directed bench for cycle_meas_ctrl with a queue-based result model
// and a negedge-updating counter standing in for the downstream hardware.
module tb_cycle_meas_ctrl;

  localparam logic [7:0] A_START  = 8'hF0;
  localparam logic [7:0] A_STOP   = 8'hF1;
  localparam logic [7:0] A_RESULT = 8'hF2;
  localparam logic [7:0] A_STATUS = 8'hF3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] cnt_value = 8'h00;
  logic       cnt_enable;
  logic       cnt_clear;
  logic [7:0] in_port_data;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: measured value is simply the number of RUN cycles mod 256.
  logic [7:0] model_q[$];
  logic       wrap_m = 1'b0;
  logic       drop_m = 1'b0;

  cycle_meas_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .cnt_value    (cnt_value),
    .cnt_enable   (cnt_enable),
    .cnt_clear    (cnt_clear),
    .in_port_data (in_port_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_clear) cnt_value <= 8'h00;
    else if (cnt_enable) cnt_value <= cnt_value + 8'h01;
  end

  function automatic logic [7:0] status_m();
    return {3'b000, wrap_m, drop_m, 1'b0, model_q.size() == 4, model_q.size() == 0};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] addr);
    port_id = addr;
    write_strobe = 1'b1;
    tick(1);
    write_strobe = 1'b0;
    port_id = 8'h00;
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] d);
    port_id = addr;
    read_strobe = 1'b1;
    #1;
    d = in_port_data;
    @(posedge clk);
    #1;
    read_strobe = 1'b0;
    port_id = 8'h00;
  endtask

  task automatic read_result(input string tag);
    logic [7:0] d, e;
    e = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
    io_read(A_RESULT, d);
    check(tag, d, e);
  endtask

  task automatic read_status(input string tag);
    logic [7:0] d, e;
    e = status_m();
    io_read(A_STATUS, d);
    check(tag, d, e);
    wrap_m = 1'b0;
    drop_m = 1'b0;
  endtask

  // n RUN cycles; optional START injected in RUN cycle inj; optional RESULT pop during CAPTURE.
  task automatic measure(input int n, input int inj, input bit pop_cap);
    logic [7:0] d, e;
    io_write(A_START);
    tick(1);
    check("run_busy", {7'd0, busy}, 8'h01);
    check("run_enable", {7'd0, cnt_enable}, 8'h01);
    for (int i = 1; i < n; i++) begin
      if (i == inj) begin
        io_write(A_START);
        check("inj_busy", {7'd0, busy}, 8'h01);
        check("inj_enable", {7'd0, cnt_enable}, 8'h01);
      end else begin
        tick(1);
      end
    end
    io_write(A_STOP);
    check("capture_enable", {7'd0, cnt_enable}, 8'h00);
    if (n >= 255) wrap_m = 1'b1;
    if (pop_cap) begin
      e = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
      io_read(A_RESULT, d);
      check("capture_pop", d, e);
      model_q.push_back(8'(n));
    end else begin
      tick(1);
      if (model_q.size() < 4) model_q.push_back(8'(n));
      else drop_m = 1'b1;
    end
    check("idle_busy", {7'd0, busy}, 8'h00);
  endtask

  initial begin
    int n;
    tick(3);
    check("reset_clear", {7'd0, cnt_clear}, 8'h01);
    check("reset_enable", {7'd0, cnt_enable}, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    reset = 1'b0;
    #1;
    check("idle_clear", {7'd0, cnt_clear}, 8'h00);
    read_status("reset_status");

    // 25-cycle measurement
    measure(25, 0, 1'b0);
    read_result("meas25_result");
    read_status("meas25_status");

    // five measurements without reads: overflow drops the fifth
    for (int k = 0; k < 5; k++) measure($urandom_range(60, 2), 0, 1'b0);
    read_status("overflow_status");
    for (int k = 0; k < 5; k++) read_result("overflow_result");
    read_status("overflow_cleared");

    // wrap past 255
    measure($urandom_range(320, 270), 0, 1'b0);
    read_status("wrap_status");
    read_status("wrap_cleared");
    read_result("wrap_result");

    // STOP in IDLE ignored, START in RUN ignored
    io_write(A_STOP);
    check("stop_idle_busy", {7'd0, busy}, 8'h00);
    check("stop_idle_enable", {7'd0, cnt_enable}, 8'h00);
    read_status("stop_idle_status");
    n = $urandom_range(40, 8);
    measure(n, $urandom_range(n - 1, 2), 1'b0);
    read_status("inj_status");
    read_result("inj_result");

    // randomized measurements interleaved with reads
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(50, 3);
      measure(n, ($urandom_range(1, 0) != 0) ? $urandom_range(n - 1, 2) : 0, 1'b0);
      if ($urandom_range(2, 0) == 0) read_result("rand_result");
      if ($urandom_range(3, 0) == 0) read_status("rand_status");
    end
    while (model_q.size() != 0) read_result("drain_result");
    read_result("drain_empty");
    read_status("drain_status");

    // reset mid-RUN aborts with no push
    measure(3, 0, 1'b0);
    io_write(A_START);
    tick(6);
    reset = 1'b1;
    #1;
    check("midrst_clear", {7'd0, cnt_clear}, 8'h01);
    tick(1);
    check("midrst_enable", {7'd0, cnt_enable}, 8'h00);
    check("midrst_clear2", {7'd0, cnt_clear}, 8'h01);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    reset = 1'b0;
    model_q.delete();
    wrap_m = 1'b0;
    drop_m = 1'b0;
    #1;
    read_status("midrst_status");
    read_result("midrst_result");

    // full FIFO: CAPTURE push coinciding with a pop succeeds, new value read last
    for (int k = 0; k < 4; k++) measure($urandom_range(90, 2), 0, 1'b0);
    measure($urandom_range(120, 91), 0, 1'b1);
    read_status("pushpop_status");
    for (int k = 0; k < 4; k++) read_result("pushpop_order");
    read_result("pushpop_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
